sync_pulse_tx: RTL and testbench

//  Transmit end of the coax timing-calibration protocol: on request, silences normal trigger forwarding,

---
 rtl/sync_cal_pkg.sv | 21 ++
 rtl/sync_pulse_tx_if.sv | 24 ++
 rtl/sync_pulse_tx.sv | 138 +++++++++++++
 tb/tb_sync_pulse_tx.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/sync_cal_pkg.sv
// Shared calibration constants and FSM state encoding for the coax sync-pulse
// transmitter and the far-end phase histogrammer.
package sync_cal_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUIET = 2'd1,
        S_BURST = 2'd2,
        S_TAIL  = 2'd3
    } cal_state_e;

    localparam int CAL_NCH     = 16;
    localparam int CAL_PERIOD  = 4;
    localparam int CAL_NPULSES = 54;
    localparam int CAL_QUIET   = 250;
    localparam int CAL_TAIL    = 200;

    // Full peer window length: quiet lead-in, pulse burst, quiet tail.
    localparam int CAL_WINDOW  = CAL_QUIET + CAL_NPULSES * CAL_PERIOD + CAL_TAIL;

endpackage

// File: rtl/sync_pulse_tx_if.sv
// Host-side signal bundle of the sync pulse transmitter: request, trigger path,
// per-channel burst configuration and status.
interface sync_pulse_tx_if #(
    parameter int NCH = 16,
    parameter int PB  = 2
);
    logic              start;
    logic [NCH-1:0]    trig_in;
    logic [NCH-1:0]    ch_mask;
    logic [NCH*PB-1:0] ch_phase;
    logic [NCH-1:0]    coax_out;
    logic              cal_active;
    logic              done;

    modport master (
        output start, trig_in, ch_mask, ch_phase,
        input  coax_out, cal_active, done
    );

    modport slave (
        input  start, trig_in, ch_mask, ch_phase,
        output coax_out, cal_active, done
    );
endinterface

// File: rtl/sync_pulse_tx.sv
// Coax timing-calibration transmitter: forwards triggers when idle, otherwise
// emits a quiet/burst/tail window of phase-binned sync pulses.
// Optional build macro AUTO_CAL_EN adds a free-running periodic auto-start.
module sync_pulse_tx
    import sync_cal_pkg::*;
#(
    parameter int NCH     = CAL_NCH,
    parameter int PERIOD  = CAL_PERIOD,
    parameter int NPULSES = CAL_NPULSES,
    parameter int QUIET   = CAL_QUIET,
    parameter int TAIL    = CAL_TAIL
) (
    input  logic           clk_adc,
    input  logic           reset,
    sync_pulse_tx_if.slave bus
);

    localparam int PB    = $clog2(PERIOD);
    localparam int TMAX  = (QUIET > TAIL) ? QUIET : TAIL;
    localparam int CW    = $clog2(TMAX + 1);
    localparam int PNW   = $clog2(NPULSES + 1);

    localparam logic [1:0] ST_IDLE  = S_IDLE;
    localparam logic [1:0] ST_QUIET = S_QUIET;
    localparam logic [1:0] ST_BURST = S_BURST;
    localparam logic [1:0] ST_TAIL  = S_TAIL;

    logic [1:0]        state;
    logic [CW-1:0]     tick_cnt;
    logic [PB-1:0]     sc;
    logic [PNW-1:0]    pn;
    logic [NCH-1:0]    mask_l;
    logic [NCH*PB-1:0] phase_l;
    logic [NCH-1:0]    hit;
    logic [NCH-1:0]    coax_q;
    logic              cal_active_q;
    logic              done_q;
    logic              start_any;

`ifdef AUTO_CAL_EN
    logic [27:0] auto_cnt;

    // Auto-start fires for the single tick bit 27 is set; it is dropped unless IDLE.
    always_ff @(posedge clk_adc) begin
        if (reset) begin
            auto_cnt <= '0;
        end else if (auto_cnt[27]) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + 28'd1;
        end
    end

    assign start_any = bus.start | auto_cnt[27];
`else
    assign start_any = bus.start;
`endif

    for (genvar j = 0; j < NCH; j++) begin : g_ch
        assign hit[j] = mask_l[j] && (sc == phase_l[PB*j +: PB]);
    end

    // Burst configuration is captured once at launch so host changes mid-window are inert.
    always_ff @(posedge clk_adc) begin
        if (state == ST_IDLE && start_any) begin
            mask_l  <= bus.ch_mask;
            phase_l <= bus.ch_phase;
        end
    end

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            state        <= ST_IDLE;
            tick_cnt     <= '0;
            sc           <= '0;
            pn           <= '0;
            coax_q       <= '0;
            cal_active_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    coax_q <= bus.trig_in;
                    if (start_any) begin
                        state        <= ST_QUIET;
                        tick_cnt     <= '0;
                        cal_active_q <= 1'b1;
                    end
                end
                ST_QUIET: begin
                    coax_q <= '0;
                    if (tick_cnt == CW'(QUIET - 1)) begin
                        state    <= ST_BURST;
                        tick_cnt <= '0;
                        sc       <= '0;
                        pn       <= '0;
                    end else begin
                        tick_cnt <= tick_cnt + CW'(1);
                    end
                end
                ST_BURST: begin
                    // PERIOD is a power of two, so sc wraps naturally at its width.
                    coax_q <= hit;
                    sc     <= sc + PB'(1);
                    if (sc == PB'(PERIOD - 1)) begin
                        if (pn == PNW'(NPULSES - 1)) begin
                            state    <= ST_TAIL;
                            tick_cnt <= '0;
                        end else begin
                            pn <= pn + PNW'(1);
                        end
                    end
                end
                ST_TAIL: begin
                    coax_q <= '0;
                    if (tick_cnt == CW'(TAIL - 1)) begin
                        state        <= ST_IDLE;
                        tick_cnt     <= '0;
                        done_q       <= 1'b1;
                        cal_active_q <= 1'b0;
                    end else begin
                        tick_cnt <= tick_cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    coax_q <= '0;
                end
            endcase
        end
    end

    assign bus.coax_out   = coax_q;
    assign bus.cal_active = cal_active_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_sync_pulse_tx.sv
// Self-checking bench for sync_pulse_tx: randomized triggers and burst configs
// compared tick by tick against a window-timeline reference model.
module tb_sync_pulse_tx;

    localparam int NCH   = 16;
    localparam int PER   = 4;
    localparam int NP    = 54;
    localparam int QT    = 250;
    localparam int TT    = 200;
    localparam int B0    = QT + 1;
    localparam int B1    = QT + NP * PER;
    localparam int WEND  = QT + NP * PER + TT;

    logic clk_adc = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    sync_pulse_tx_if #(.NCH(NCH), .PB(2)) bus ();

    sync_pulse_tx dut (
        .clk_adc (clk_adc),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_adc = ~clk_adc;

    task automatic tick();
        @(posedge clk_adc);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // k = number of clock edges since the edge that sampled start.
    function automatic logic [15:0] exp_coax(int k, logic [15:0] m, logic [31:0] ph,
                                             logic [15:0] tr);
        logic [15:0] r;
        int slot;
        r = '0;
        if (k == 0 || k > WEND) begin
            r = tr;
        end else if (k >= B0 && k <= B1) begin
            slot = (k - B0) % PER;
            for (int j = 0; j < NCH; j++)
                r[j] = m[j] && (int'(ph[2*j +: 2]) == slot);
        end
        return r;
    endfunction

    task automatic run_window(input logic [15:0] m, input logic [31:0] ph,
                              input bit perturb, input int abort_k, input string tag);
        logic [15:0] tr;
        int hist[NCH][PER];
        bit aborted;
        aborted = 1'b0;
        for (int j = 0; j < NCH; j++)
            for (int b = 0; b < PER; b++)
                hist[j][b] = 0;

        bus.ch_mask  = m;
        bus.ch_phase = ph;
        bus.start    = 1'b1;
        tr           = 16'($urandom);
        bus.trig_in  = tr;
        tick();
        bus.start = 1'b0;
        chk({tag, " coax k=0"}, bus.coax_out, tr);
        chk({tag, " cal k=0"}, 16'(bus.cal_active), 16'd1);
        chk({tag, " done k=0"}, 16'(bus.done), 16'd0);

        for (int k = 1; k <= WEND + 1; k++) begin
            tr          = 16'($urandom);
            bus.trig_in = tr;
            if (perturb && k <= WEND) begin
                bus.start    = 1'($urandom);
                bus.ch_mask  = 16'($urandom);
                bus.ch_phase = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            if (k == abort_k) begin
                bus.start = 1'b0;
                reset     = 1'b1;
                tick();
                reset = 1'b0;
                chk($sformatf("%s abort coax k=%0d", tag, k), bus.coax_out, 16'h0000);
                chk($sformatf("%s abort cal k=%0d", tag, k), 16'(bus.cal_active), 16'd0);
                chk($sformatf("%s abort done k=%0d", tag, k), 16'(bus.done), 16'd0);
                aborted = 1'b1;
                break;
            end
            tick();
            chk($sformatf("%s coax k=%0d", tag, k), bus.coax_out, exp_coax(k, m, ph, tr));
            chk($sformatf("%s cal k=%0d", tag, k), 16'(bus.cal_active), 16'(k < WEND));
            chk($sformatf("%s done k=%0d", tag, k), 16'(bus.done), 16'(k == WEND));
            if (k >= B0 && k <= B1)
                for (int j = 0; j < NCH; j++)
                    if (bus.coax_out[j] === 1'b1) hist[j][(k - B0) % PER]++;
        end
        bus.start = 1'b0;

        if (!aborted)
            for (int j = 0; j < NCH; j++)
                for (int b = 0; b < PER; b++)
                    chk($sformatf("%s hist ch%0d bin%0d", tag, j, b), 16'(hist[j][b]),
                        (m[j] && int'(ph[2*j +: 2]) == b) ? 16'(NP) : 16'd0);
    endtask

    initial begin
        logic [15:0] tr;
        reset        = 1'b1;
        bus.start    = 1'b1;
        bus.trig_in  = 16'hFFFF;
        bus.ch_mask  = 16'hFFFF;
        bus.ch_phase = '0;
        repeat (3) tick();
        chk("reset coax", bus.coax_out, 16'h0000);
        chk("reset cal", 16'(bus.cal_active), 16'd0);
        chk("reset done", 16'(bus.done), 16'd0);

        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.trig_in = 16'hA5A5;
        tick();
        chk("fwd A5A5", bus.coax_out, 16'hA5A5);
        chk("fwd cal", 16'(bus.cal_active), 16'd0);
        chk("fwd done", 16'(bus.done), 16'd0);
        for (int i = 0; i < 8; i++) begin
            tr          = 16'($urandom);
            bus.trig_in = tr;
            tick();
            chk($sformatf("fwd rand %0d", i), bus.coax_out, tr);
        end

        run_window(16'hFFFF, 32'hAAAA_AAAA, 1'b0, 0, "all_ph2");
        run_window(16'h0001, 32'h0000_0003, 1'b0, 0, "ch0_ph3");
        run_window(16'($urandom), $urandom, 1'b1, 0, "perturb");

        run_window(16'($urandom), $urandom, 1'b0, B0 + 20 * PER, "abort");
        for (int i = 0; i < 6; i++) begin
            tr          = 16'($urandom);
            bus.trig_in = tr;
            tick();
            chk($sformatf("post-abort fwd %0d", i), bus.coax_out, tr);
            chk($sformatf("post-abort done %0d", i), 16'(bus.done), 16'd0);
        end
        run_window(16'($urandom), $urandom, 1'b0, 0, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
